// File: rtl/zeroheti_pkg.sv
// Shared widths, state type and address helper for the zeroheti APB-to-OBI bridge.
package zeroheti_pkg;

  localparam int unsigned ApbAw = 32;
  localparam int unsigned ApbDw = 32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    DONE
  } apb2obi_state_e;

  function automatic logic [ApbAw-1:0] apb2obi_word_addr(input logic [ApbAw-1:0] addr);
    return {addr[ApbAw-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/zeroheti_apb_to_obi_if.sv
// APB4 and OBI bus bundles used by the APB-to-OBI bridge.
// master = bus requester/manager side, slave = completer/subordinate side.
interface zeroheti_apb_if;
  import zeroheti_pkg::*;

  logic             psel;
  logic             penable;
  logic             pwrite;
  logic [ApbAw-1:0] paddr;
  logic [ApbDw-1:0] pwdata;
  logic [3:0]       pstrb;
  logic             pready;
  logic [ApbDw-1:0] prdata;
  logic             pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output pready, prdata, pslverr
  );
endinterface

interface zeroheti_obi_if;
  import zeroheti_pkg::*;

  logic             req;
  logic             gnt;
  logic [ApbAw-1:0] addr;
  logic             we;
  logic [3:0]       be;
  logic [ApbDw-1:0] wdata;
  logic             rvalid;
  logic [ApbDw-1:0] rdata;
  logic             err;

  modport master (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/zeroheti_apb2obi_range_chk.sv
// In-window compare for translated bridge addresses: RangeBase <= addr < RangeBase+RangeSize.
// Compiled only when ZEROHETI_APB2OBI_RANGE_CHK_EN is defined.
`ifdef ZEROHETI_APB2OBI_RANGE_CHK_EN
module zeroheti_apb2obi_range_chk
  import zeroheti_pkg::*;
#(
  parameter logic [ApbAw-1:0] RangeBase = 32'h0000_0000,
  parameter logic [ApbAw-1:0] RangeSize = 32'h0001_0000
) (
  input  logic [ApbAw-1:0] i_addr,
  output logic             o_in_range
);

  logic [ApbAw-1:0] w_rel;

  // Offset form avoids overflow when RangeBase+RangeSize reaches 2^32.
  always_comb begin
    w_rel      = i_addr - RangeBase;
    o_in_range = (i_addr >= RangeBase) && (w_rel < RangeSize);
  end

endmodule
`endif

// File: rtl/zeroheti_apb_to_obi.sv
// APB4 completer to OBI manager bridge; one transaction in flight, all outputs registered.
// Define ZEROHETI_APB2OBI_RANGE_CHK_EN to reject translated addresses outside the Range window.
module zeroheti_apb_to_obi
  import zeroheti_pkg::*;
#(
  parameter logic [ApbAw-1:0] AddrOffset = 32'h0000_0000,
  parameter logic [ApbAw-1:0] RangeBase  = 32'h0000_0000,
  parameter logic [ApbAw-1:0] RangeSize  = 32'h0001_0000
) (
  input logic            clk_i,
  input logic            rst_i,
  zeroheti_apb_if.slave  apb,
  zeroheti_obi_if.master obi
);

  if ((RangeSize == '0) || (RangeSize[1:0] != 2'b00) ||
      (({1'b0, RangeBase} + {1'b0, RangeSize}) > 33'h1_0000_0000)) begin : g_bad_range_cfg
    $error("zeroheti_apb_to_obi: RangeSize must be nonzero, word-multiple and fit the address space");
  end

  apb2obi_state_e   r_state;
  logic             r_req;
  logic [ApbAw-1:0] r_addr;
  logic             r_we;
  logic [3:0]       r_be;
  logic [ApbDw-1:0] r_wdata;
  logic             r_pready;
  logic [ApbDw-1:0] r_prdata;
  logic             r_pslverr;

  logic [ApbAw-1:0] w_addr_sum;
  logic [ApbAw-1:0] w_addr;
  logic             w_setup;
  logic             w_in_range;

  assign w_addr_sum = apb.paddr + AddrOffset;
  assign w_addr     = apb2obi_word_addr(w_addr_sum);
  assign w_setup    = apb.psel && !apb.penable;

`ifdef ZEROHETI_APB2OBI_RANGE_CHK_EN
  zeroheti_apb2obi_range_chk #(
    .RangeBase (RangeBase),
    .RangeSize (RangeSize)
  ) u_range_chk (
    .i_addr     (w_addr),
    .o_in_range (w_in_range)
  );
`else
  assign w_in_range = 1'b1;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_req     <= 1'b0;
      r_addr    <= '0;
      r_we      <= 1'b0;
      r_be      <= '0;
      r_wdata   <= '0;
      r_pready  <= 1'b0;
      r_prdata  <= '0;
      r_pslverr <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_pready  <= 1'b0;
          r_prdata  <= '0;
          r_pslverr <= 1'b0;
          if (w_setup) begin
            r_addr  <= w_addr;
            r_we    <= apb.pwrite;
            r_be    <= apb.pwrite ? apb.pstrb : '1;
            r_wdata <= apb.pwdata;
            // Out-of-window accesses complete directly with an error, no OBI traffic.
            if (w_in_range) begin
              r_req   <= 1'b1;
              r_state <= REQ;
            end else begin
              r_pready  <= 1'b1;
              r_pslverr <= 1'b1;
              r_state   <= DONE;
            end
          end
        end
        REQ: begin
          if (obi.gnt) begin
            r_req   <= 1'b0;
            r_state <= RESP;
          end
        end
        RESP: begin
          if (obi.rvalid) begin
            r_prdata  <= r_we ? '0 : obi.rdata;
            r_pslverr <= obi.err;
            r_pready  <= 1'b1;
            r_state   <= DONE;
          end
        end
        DONE: begin
          r_pready  <= 1'b0;
          r_prdata  <= '0;
          r_pslverr <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  assign obi.req     = r_req;
  assign obi.addr    = r_addr;
  assign obi.we      = r_we;
  assign obi.be      = r_be;
  assign obi.wdata   = r_wdata;
  assign apb.pready  = r_pready;
  assign apb.prdata  = r_prdata;
  assign apb.pslverr = r_pslverr;

endmodule

// File: tb/tb_zeroheti_apb_to_obi.sv
// Bench for zeroheti_apb_to_obi: directed cases plus randomized APB traffic against a
// transaction-phase reference model and a byte-accurate memory model.
module tb_zeroheti_apb_to_obi;

  logic clk = 1'b0;
  logic rst0, rst1;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  zeroheti_apb_if apb0 ();
  zeroheti_obi_if obi0 ();
  zeroheti_apb_if apb1 ();
  zeroheti_obi_if obi1 ();

  zeroheti_apb_to_obi #(
    .AddrOffset (32'h0000_0000),
    .RangeBase  (32'h0000_1000),
    .RangeSize  (32'h0000_0100)
  ) u_dut0 (
    .clk_i (clk),
    .rst_i (rst0),
    .apb   (apb0),
    .obi   (obi0)
  );

  zeroheti_apb_to_obi #(
    .AddrOffset (32'hFFFF_FFF0)
  ) u_dut1 (
    .clk_i (clk),
    .rst_i (rst1),
    .apb   (apb1),
    .obi   (obi1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Memory: bench reference view vs. the OBI subordinate's own storage
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] slv_mem [logic [31:0]];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] slv_rd(input logic [31:0] a);
    return slv_mem.exists(a) ? slv_mem[a] : init_word(a);
  endfunction

  // Reference model: transaction phases of dut0 (waiting for grant / response / completion pulse)
  bit          started = 1'b0;
  bit          m_req = 1'b0, m_wait = 1'b0, m_pready = 1'b0;
  logic [31:0] e_addr, e_wdata, e_rd, m_prdata;
  logic        e_we, m_pslverr, e_fwd;
  logic [3:0]  e_be;
  int unsigned req_cycles = 0, pready_cnt = 0;

  initial begin : compare_proc
    forever begin
      @(negedge clk);
      if (started) begin
        chk("obi_req", 32'(obi0.req), 32'(m_req));
        if (m_req) begin
          chk("obi_addr", obi0.addr, e_addr);
          chk("obi_we", 32'(obi0.we), 32'(e_we));
          chk("obi_be", 32'(obi0.be), 32'(e_be));
          chk("obi_wdata", obi0.wdata, e_wdata);
        end
        chk("apb_pready", 32'(apb0.pready), 32'(m_pready));
        chk("apb_prdata", apb0.prdata, m_pready ? m_prdata : 32'h0);
        chk("apb_pslverr", 32'(apb0.pslverr), m_pready ? 32'(m_pslverr) : 32'h0);
        if (obi0.req) req_cycles++;
        if (apb0.pready) pready_cnt++;

        if (rst0) begin
          m_req = 1'b0; m_wait = 1'b0; m_pready = 1'b0;
        end else if (m_pready) begin
          m_pready = 1'b0;
        end else if (m_req) begin
          if (obi0.gnt) begin m_req = 1'b0; m_wait = 1'b1; end
        end else if (m_wait) begin
          if (obi0.rvalid) begin
            m_wait    = 1'b0;
            m_pready  = 1'b1;
            m_prdata  = e_we ? 32'h0 : e_rd;
            m_pslverr = obi0.err;
          end
        end else if (apb0.psel && !apb0.penable) begin
          e_addr  = apb0.paddr & ~32'h3;
          e_we    = apb0.pwrite;
          e_be    = apb0.pwrite ? apb0.pstrb : 4'hF;
          e_wdata = apb0.pwdata;
`ifdef ZEROHETI_APB2OBI_RANGE_CHK_EN
          e_fwd = (e_addr >= 32'h1000) && (e_addr < 32'h1100);
`else
          e_fwd = 1'b1;
`endif
          if (e_fwd) begin
            e_rd = ref_rd(e_addr);
            if (e_we) ref_mem[e_addr] = merge(e_rd, e_wdata, e_be);
            m_req = 1'b1;
          end else begin
            m_pready = 1'b1; m_prdata = 32'h0; m_pslverr = 1'b1;
          end
        end
      end
    end
  end

  // OBI subordinate for dut0 (cfg_* < 0 means randomized)
  bit          rs_en = 1'b1, rs_inreq = 1'b0, rs_busy = 1'b0, rs_err;
  int          rs_gcnt, rs_cnt;
  int          cfg_gnt_wait = -1, cfg_rv_wait = -1, cfg_err = -1;
  logic [31:0] rs_rdata, rs_last_addr, rs_last_wdata, cur;
  logic [3:0]  rs_last_be;
  logic        rs_last_we;

  initial begin : responder
    forever begin
      @(posedge clk); #1;
      if (rs_en) begin
        obi0.gnt = 1'b0; obi0.rvalid = 1'b0; obi0.err = 1'b0; obi0.rdata = $urandom;
        if (rs_busy) begin
          if (rs_cnt == 0) begin
            obi0.rvalid = 1'b1; obi0.rdata = rs_rdata; obi0.err = rs_err; rs_busy = 1'b0;
          end else rs_cnt--;
        end else if (obi0.req) begin
          if (!rs_inreq) begin
            rs_inreq = 1'b1;
            rs_gcnt  = (cfg_gnt_wait < 0) ? int'($urandom_range(0, 3)) : cfg_gnt_wait;
          end
          if (rs_gcnt == 0) begin
            rs_inreq = 1'b0;
            rs_last_addr = obi0.addr; rs_last_we = obi0.we;
            rs_last_be = obi0.be; rs_last_wdata = obi0.wdata;
            cur = slv_rd(obi0.addr);
            if (obi0.we) begin
              slv_mem[obi0.addr] = merge(cur, obi0.wdata, obi0.be);
              rs_rdata = $urandom;
            end else rs_rdata = cur;
            rs_err  = (cfg_err < 0) ? ($urandom_range(0, 7) == 0) : (cfg_err != 0);
            rs_cnt  = ((cfg_rv_wait < 0) ? int'($urandom_range(1, 3)) : cfg_rv_wait) - 1;
            rs_busy = 1'b1;
            obi0.gnt = 1'b1;
          end else rs_gcnt--;
        end else if ($urandom_range(0, 5) == 0) begin
          obi0.rvalid = 1'b1;  // stray response, must be ignored
        end
      end
    end
  end

  task automatic apb_xfer(input logic we, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input bit drop,
                          output int lat, output logic [31:0] rd, output logic er);
    bit done;
    done = 1'b0; lat = 0; rd = 'x; er = 'x;
    @(posedge clk); #1;
    apb0.psel = 1'b1; apb0.penable = 1'b0; apb0.pwrite = we;
    apb0.paddr = a; apb0.pwdata = d; apb0.pstrb = s;
    @(posedge clk); #1;
    apb0.penable = 1'b1;
    if (drop) begin apb0.psel = 1'b0; apb0.penable = 1'b0; end
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      lat = i + 1;
      if (apb0.pready) begin done = 1'b1; rd = apb0.prdata; er = apb0.pslverr; end
    end
    chk("apb_pready_timeout", 32'(done), 32'h1);
    @(posedge clk); #1;
    apb0.psel = 1'b0; apb0.penable = 1'b0;
  endtask

  task automatic dut1_read(input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] oa, output logic oreq,
                           output logic pr, output logic [31:0] rd);
    @(posedge clk); #1;
    apb1.psel = 1'b1; apb1.penable = 1'b0; apb1.pwrite = 1'b0; apb1.paddr = a;
    @(posedge clk); #1;
    apb1.penable = 1'b1;
    @(negedge clk);
    oa = obi1.addr; oreq = obi1.req;
    @(posedge clk); #1;
    obi1.rvalid = 1'b1; obi1.rdata = d;
    @(posedge clk); #1;
    obi1.rvalid = 1'b0;
    @(negedge clk);
    pr = apb1.pready; rd = apb1.prdata;
    @(posedge clk); #1;
    apb1.psel = 1'b0; apb1.penable = 1'b0;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_tests=%0d", n_tests);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int          lat, sel;
    int unsigned r0, p0;
    logic [31:0] rd, a, oa;
    logic        er, oreq, pr;

    rst0 = 1'b1; rst1 = 1'b1;
    apb0.psel = 1'b0; apb0.penable = 1'b0; apb0.pwrite = 1'b0;
    apb0.paddr = '0; apb0.pwdata = '0; apb0.pstrb = '0;
    apb1.psel = 1'b0; apb1.penable = 1'b0; apb1.pwrite = 1'b0;
    apb1.paddr = '0; apb1.pwdata = '0; apb1.pstrb = '0;
    obi0.gnt = 1'b0; obi0.rvalid = 1'b0; obi0.rdata = '0; obi0.err = 1'b0;
    obi1.gnt = 1'b1; obi1.rvalid = 1'b0; obi1.rdata = '0; obi1.err = 1'b0;

    @(posedge clk);
    started = 1'b1;
    @(negedge clk);
    chk("rst_req", 32'(obi0.req), 32'h0);
    chk("rst_addr", obi0.addr, 32'h0);
    chk("rst_pready", 32'(apb0.pready), 32'h0);
    chk("rst_prdata", apb0.prdata, 32'h0);
    chk("rst_pslverr", 32'(apb0.pslverr), 32'h0);
    chk("rst1_req", 32'(obi1.req), 32'h0);
    @(posedge clk); #1;
    rst0 = 1'b0; rst1 = 1'b0;

    // 1: zero-wait read
    cfg_gnt_wait = 0; cfg_rv_wait = 1; cfg_err = 0;
    ref_mem[32'h1004] = 32'hDEADBEEF; slv_mem[32'h1004] = 32'hDEADBEEF;
    apb_xfer(1'b0, 32'h0000_1004, 32'h0, 4'h0, 1'b0, lat, rd, er);
    chk("t1_obi_addr", rs_last_addr, 32'h0000_1004);
    chk("t1_obi_be", 32'(rs_last_be), 32'hF);
    chk("t1_obi_we", 32'(rs_last_we), 32'h0);
    chk("t1_latency", 32'(lat), 32'd3);
    chk("t1_prdata", rd, 32'hDEADBEEF);
    chk("t1_pslverr", 32'(er), 32'h0);

    // 2: write with grant delayed 3 cycles
    cfg_gnt_wait = 3;
    r0 = req_cycles; p0 = pready_cnt;
    apb_xfer(1'b1, 32'h0000_1008, 32'h1234_5678, 4'b0011, 1'b0, lat, rd, er);
    chk("t2_req_cycles", req_cycles - r0, 32'd4);
    chk("t2_pready_pulses", pready_cnt - p0, 32'd1);
    chk("t2_latency", 32'(lat), 32'd6);
    chk("t2_prdata", rd, 32'h0);
    chk("t2_obi_be", 32'(rs_last_be), 32'h3);
    chk("t2_obi_wdata", rs_last_wdata, 32'h1234_5678);
    cfg_gnt_wait = 0;
    apb_xfer(1'b0, 32'h0000_1008, 32'h0, 4'h0, 1'b0, lat, rd, er);
    chk("t2_readback", rd, 32'hA5A5_5678);

    // 3: OBI error on read
    cfg_err = 1;
    apb_xfer(1'b0, 32'h0000_100C, 32'h0, 4'h0, 1'b0, lat, rd, er);
    chk("t3_pslverr", 32'(er), 32'h1);
    chk("t3_prdata", rd, 32'hA5A5_100C);
    chk("t3_latency", 32'(lat), 32'd3);
    cfg_err = 0;

    // 4: reset while waiting for grant, then a stray response
    rs_en = 1'b0;
    obi0.gnt = 1'b0; obi0.rvalid = 1'b0; obi0.err = 1'b0;
    p0 = pready_cnt;
    @(posedge clk); #1;
    apb0.psel = 1'b1; apb0.penable = 1'b0; apb0.pwrite = 1'b0; apb0.paddr = 32'h1010;
    @(posedge clk); #1;
    apb0.penable = 1'b1; rst0 = 1'b1;
    @(negedge clk);
    chk("t4_req_before_rst", 32'(obi0.req), 32'h1);
    @(posedge clk); #1;
    rst0 = 1'b0; apb0.psel = 1'b0; apb0.penable = 1'b0;
    @(negedge clk);
    chk("t4_req_after_rst", 32'(obi0.req), 32'h0);
    chk("t4_pready_after_rst", 32'(apb0.pready), 32'h0);
    @(posedge clk); #1;
    obi0.rvalid = 1'b1; obi0.rdata = 32'hBAD0_BAD0; obi0.err = 1'b1;
    @(posedge clk); #1;
    obi0.rvalid = 1'b0; obi0.err = 1'b0;
    repeat (3) @(posedge clk);
    chk("t4_no_pready", pready_cnt - p0, 32'd0);
    rs_busy = 1'b0; rs_inreq = 1'b0;
    @(posedge clk); #1;
    rs_en = 1'b1;

    // 5: address offset wraps modulo 2^32 and is word-aligned
    dut1_read(32'h0000_0020, 32'h0102_0304, oa, oreq, pr, rd);
    chk("t5_wrap_addr", oa, 32'h0000_0010);
    chk("t5_wrap_req", 32'(oreq), 32'h1);
    chk("t5_wrap_pready", 32'(pr), 32'h1);
    chk("t5_wrap_prdata", rd, 32'h0102_0304);
    dut1_read(32'h0000_0023, 32'hCAFE_F00D, oa, oreq, pr, rd);
    chk("t5_align_addr", oa, 32'h0000_0010);
    chk("t5_align_prdata", rd, 32'hCAFE_F00D);

    // 6: window boundary
    r0 = req_cycles;
    apb_xfer(1'b0, 32'h0000_1100, 32'h0, 4'h0, 1'b0, lat, rd, er);
`ifdef ZEROHETI_APB2OBI_RANGE_CHK_EN
    chk("t6_reject_latency", 32'(lat), 32'd1);
    chk("t6_reject_pslverr", 32'(er), 32'h1);
    chk("t6_reject_prdata", rd, 32'h0);
    chk("t6_reject_no_req", req_cycles - r0, 32'd0);
`else
    chk("t6_fwd_latency", 32'(lat), 32'd3);
    chk("t6_fwd_pslverr", 32'(er), 32'h0);
    chk("t6_fwd_req", req_cycles - r0, 32'd1);
`endif
    r0 = req_cycles;
    apb_xfer(1'b0, 32'h0000_10FC, 32'h0, 4'h0, 1'b0, lat, rd, er);
    chk("t6_edge_latency", 32'(lat), 32'd3);
    chk("t6_edge_pslverr", 32'(er), 32'h0);
    chk("t6_edge_prdata", rd, 32'hA5A5_10FC);
    chk("t6_edge_req", req_cycles - r0, 32'd1);

    // Randomized traffic
    cfg_gnt_wait = -1; cfg_rv_wait = -1; cfg_err = -1;
    for (int k = 0; k < 300; k++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 6)      a = 32'h1000 + $urandom_range(0, 255);
      else if (sel < 8) a = 32'h0FF0 + $urandom_range(0, 47);
      else if (sel < 9) a = 32'h10F0 + $urandom_range(0, 31);
      else              a = $urandom;
      apb_xfer(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
               ($urandom_range(0, 15) == 0), lat, rd, er);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
